rom_arb_23128: RTL and testbench
================================

ROM_ARB_23128 -- requirements
Module: rom_arb_23128

Interface
REQ-001 Parameter: WAIT_CYCLES, 2, extra ROM access cycles after the first (legal 0..15).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_b  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 Port: req0 / req1  input  1 each  access request, port 0 = CPU, port 1 = DMA/video.
REQ-005 Port: addr0 / addr1  input  14 each  requester byte address.
REQ-006 Port: ack0 / ack1  output  1 each  access complete, read data valid.
REQ-007 Port: rdata0 / rdata1  output  8 each  read data returned to each requester.
REQ-008 Port: rom_A  output  14  address to the 23128 controller.
REQ-009 Port: rom_CS_b, rom_OE_b, rom_CE1_b, rom_CE2_b  output  1 each  active-low ROM selects.
REQ-010 Port: rom_D  input  8  ROM data bus, valid only while all selects are low.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states IDLE, ACCESS, DONE; all outputs registered.
REQ-013 IDLE: all ROM selects high, rom_A = 0, acks low.
REQ-014 IDLE with any req high: arbitrate, latch winner's address into rom_A, record winner, load wait counter with WAIT_CYCLES, go ACCESS.
REQ-015 ACCESS: all four selects low, rom_A held; counter decrements each cycle; when counter = 0, capture rom_D into winner's rdata register and go DONE.
REQ-016 ACCESS lasts exactly WAIT_CYCLES+1 cycles; WAIT_CYCLES = 0 gives a single ACCESS cycle.
REQ-017 DONE: selects high; winner's ack high; ack held until winner's req samples low, then IDLE (four-phase handshake).
REQ-018 Latency: req sampled high in IDLE at edge t -> ack high after edge t+WAIT_CYCLES+2.
REQ-019 rdataN holds last captured value until overwritten by a later access on port N; loser's rdata and ack unaffected.
REQ-020 Requester holds req and address stable until ack; address changes after grant are ignored.
REQ-021 req dropped during ACCESS: access completes, data captured, DONE exits on first cycle req is low (ack pulses one cycle).
REQ-022 Other port's req during ACCESS/DONE is held pending and arbitrated on return to IDLE; no overlap of accesses.
REQ-023 Only one ack high at any time; never both.

Reset
REQ-024 rst_b low at a rising edge: state IDLE, ack0/ack1 = 0, rdata0/rdata1 = 8'h00, rom_A = 0, all selects = 1, busy = 0, counter = 0, last-grant = port 1.
REQ-025 Reset mid-ACCESS or mid-DONE aborts the access with no ack and no data capture; first arbitration after reset release uses reset last-grant.

Configuration
REQ-026 Macro ROM_ARB_ROUND_ROBIN_EN defined: simultaneous req0 and req1 in IDLE grant the port not granted last; last-grant updates on every grant.
REQ-027 Macro undefined: fixed priority, req0 always wins ties; last-grant register absent; single-requester behaviour identical in both builds.

Verification
REQ-028 WAIT_CYCLES=2, req0 addr 14'h0123, rom_D = 8'hA5 -> selects low 3 cycles, ack0 after edge t+4, rdata0 = 8'hA5, ack0 falls one cycle after req0 drops.
REQ-029 req0 and req1 raised same cycle, held through three rounds, ROUND_ROBIN_EN defined -> grant order 0,1,0; undefined -> 0,0,0 with port 1 starved while req0 repeats.
REQ-030 WAIT_CYCLES=0, req1 addr 14'h3FFF, rom_D = 8'h5A -> one ACCESS cycle, ack1 after edge t+2, rom_A = 14'h3FFF during access.
REQ-031 rst_b low on second ACCESS cycle -> next cycle selects high, no ack, rdata0 = 8'h00, busy = 0.
REQ-032 req1 raised during port-0 ACCESS -> port 1 served immediately after port-0 handshake closes, ack0 and ack1 never overlap, selects never low outside ACCESS.

Source files
------------

// File: rtl/rom_arb_23128_if.sv
// Requester and ROM-side signal bundle for the rom_arb_23128 arbiter.
// The slave modport belongs to the arbiter. The master modport belongs to the requesters and the ROM.
interface rom_arb_23128_if;
    logic        req0;
    logic        req1;
    logic [13:0] addr0;
    logic [13:0] addr1;
    logic        ack0;
    logic        ack1;
    logic [7:0]  rdata0;
    logic [7:0]  rdata1;
    logic [13:0] rom_A;
    logic        rom_CS_b;
    logic        rom_OE_b;
    logic        rom_CE1_b;
    logic        rom_CE2_b;
    logic [7:0]  rom_D;
    logic        busy;

    modport slave (
        input  req0, req1, addr0, addr1, rom_D,
        output ack0, ack1, rdata0, rdata1, rom_A,
               rom_CS_b, rom_OE_b, rom_CE1_b, rom_CE2_b, busy
    );

    modport master (
        output req0, req1, addr0, addr1, rom_D,
        input  ack0, ack1, rdata0, rdata1, rom_A,
               rom_CS_b, rom_OE_b, rom_CE1_b, rom_CE2_b, busy
    );
endinterface

// File: rtl/rom_arb_23128.sv
// Two-port arbiter in front of a 23128 ROM. It performs one access at a time with a four-phase req/ack handshake.
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking. Otherwise port 0 has fixed priority.
module rom_arb_23128 #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    rom_arb_23128_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              winner, winner_nxt;
    logic [13:0]       rom_a, rom_a_nxt;
    logic              sel_b, sel_b_nxt;
    logic [1:0]        ack, ack_nxt;
    logic [1:0][7:0]   rdata, rdata_nxt;
    logic [1:0]        req;
    logic [1:0][13:0]  addr;
    logic              grant;

    assign req  = {bus.req1, bus.req0};
    assign addr = {bus.addr1, bus.addr0};

`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic last, last_nxt;

    always_comb begin
        if (req == 2'b11) grant = ~last;
        else              grant = req[1] & ~req[0];
    end
`else
    always_comb begin
        grant = req[1] & ~req[0];
    end
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        winner_nxt = winner;
        rom_a_nxt  = rom_a;
        sel_b_nxt  = 1'b1;
        ack_nxt    = 2'b00;
        rdata_nxt  = rdata;
`ifdef ROM_ARB_ROUND_ROBIN_EN
        last_nxt   = last;
`endif
        case (state)
            IDLE: begin
                rom_a_nxt = '0;
                if (|req) begin
                    state_nxt  = ACCESS;
                    rom_a_nxt  = addr[grant];
                    winner_nxt = grant;
                    cnt_nxt    = 4'(WAIT_CYCLES);
                    sel_b_nxt  = 1'b0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
                    last_nxt   = grant;
`endif
                end
            end
            ACCESS: begin
                sel_b_nxt = 1'b0;
                if (cnt == 4'd0) begin
                    // The selects have been low for this whole cycle, so rom_D is valid here.
                    rdata_nxt[winner] = bus.rom_D;
                    state_nxt         = DONE;
                    sel_b_nxt         = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                // Ack always rises on the first DONE cycle, so a req dropped early still sees a one-cycle pulse.
                ack_nxt[winner] = req[winner] | ~ack[winner];
                if (!req[winner]) begin
                    state_nxt = IDLE;
                    rom_a_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                rom_a_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state  <= IDLE;
            cnt    <= '0;
            winner <= 1'b0;
            rom_a  <= '0;
            sel_b  <= 1'b1;
            ack    <= '0;
            rdata  <= '0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            last   <= 1'b1;
`endif
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            winner <= winner_nxt;
            rom_a  <= rom_a_nxt;
            sel_b  <= sel_b_nxt;
            ack    <= ack_nxt;
            rdata  <= rdata_nxt;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            last   <= last_nxt;
`endif
        end
    end

    assign bus.ack0      = ack[0];
    assign bus.ack1      = ack[1];
    assign bus.rdata0    = rdata[0];
    assign bus.rdata1    = rdata[1];
    assign bus.rom_A     = rom_a;
    assign bus.rom_CS_b  = sel_b;
    assign bus.rom_OE_b  = sel_b;
    assign bus.rom_CE1_b = sel_b;
    assign bus.rom_CE2_b = sel_b;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_rom_arb_23128.sv
// Scoreboard bench for rom_arb_23128. It runs one instance with WAIT_CYCLES=2 and one with WAIT_CYCLES=0.
// Both instances share a behavioural ROM whose output is only valid while the selects are low.
module tb_rom_arb_23128;
    logic clk;
    logic rst_b;
    int   checks;
    int   errors;

    typedef struct {
        logic       port;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    rom_arb_23128_if b2();
    rom_arb_23128_if b0();

    rom_arb_23128 #(.WAIT_CYCLES(2)) dut2 (.clk(clk), .rst_b(rst_b), .bus(b2));
    rom_arb_23128 #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_b(rst_b), .bus(b0));

    function automatic logic [7:0] rom_f(input logic [13:0] a);
        if (a == 14'h0123) return 8'hA5;
        if (a == 14'h3FFF) return 8'h5A;
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3C;
    endfunction

    wire sel2_low = ~(b2.rom_CS_b | b2.rom_OE_b | b2.rom_CE1_b | b2.rom_CE2_b);
    wire sel2_any = ~(b2.rom_CS_b & b2.rom_OE_b & b2.rom_CE1_b & b2.rom_CE2_b);
    wire sel0_low = ~(b0.rom_CS_b | b0.rom_OE_b | b0.rom_CE1_b | b0.rom_CE2_b);
    wire sel0_any = ~(b0.rom_CS_b & b0.rom_OE_b & b0.rom_CE1_b & b0.rom_CE2_b);

    assign b2.rom_D = sel2_low ? rom_f(b2.rom_A) : 8'hEE;
    assign b0.rom_D = sel0_low ? rom_f(b0.rom_A) : 8'hEE;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns the first port seen acking, or -1 when the budget runs out. Iteration i samples after the (i+1)th edge.
    task automatic wait_ack2(input int budget, output int port, output int k);
        port = -1;
        k    = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (b2.ack0 || b2.ack1) begin
                port = b2.ack0 ? 0 : 1;
                k    = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (b2.ack0 !== 1'b0 || b2.ack1 !== 1'b0 || b2.rdata0 !== 8'h00 || b2.rdata1 !== 8'h00 ||
            b2.rom_A !== 14'h0 || sel2_any !== 1'b0 || b2.busy !== 1'b0) begin
            $display("FAIL reset_w2: ack=%b%b rdata=%h/%h A=%h sel_any=%b busy=%b, want all zero, selects high",
                     b2.ack1, b2.ack0, b2.rdata1, b2.rdata0, b2.rom_A, sel2_any, b2.busy);
            errors++;
        end
        checks++;
        if (b0.ack0 !== 1'b0 || b0.ack1 !== 1'b0 || b0.rdata0 !== 8'h00 || b0.rdata1 !== 8'h00 ||
            b0.rom_A !== 14'h0 || sel0_any !== 1'b0 || b0.busy !== 1'b0) begin
            $display("FAIL reset_w0: ack=%b%b rdata=%h/%h A=%h sel_any=%b busy=%b, want all zero, selects high",
                     b0.ack1, b0.ack0, b0.rdata1, b0.rdata0, b0.rom_A, sel0_any, b0.busy);
            errors++;
        end
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int   sel_n, ack_k;
        bit   a_ok;
        exp_t e;
        sel_n = 0; ack_k = -1; a_ok = 1'b1;
        b2.addr0 = 14'h0123;
        b2.req0  = 1'b1;
        e.port = 1'b0; e.data = rom_f(14'h0123);
        sb.push_back(e);
        for (int i = 0; i < 20 && ack_k < 0; i++) begin
            @(negedge clk);
            if (sel2_low) begin
                sel_n++;
                if (b2.rom_A !== 14'h0123) a_ok = 1'b0;
            end
            if (b2.ack0) ack_k = i;
        end
        checks++;
        if (ack_k !== 4) begin $display("FAIL basic_latency: ack0 after edge t+%0d, want t+4", ack_k); errors++; end
        checks++;
        if (sel_n !== 3) begin $display("FAIL basic_sel_cycles: %0d, want 3", sel_n); errors++; end
        checks++;
        if (!a_ok) begin $display("FAIL basic_rom_A: address not 0123 during access"); errors++; end
        e = sb.pop_front();
        checks++;
        if (b2.rdata0 !== e.data) begin $display("FAIL basic_rdata0: %h, want %h", b2.rdata0, e.data); errors++; end
        b2.req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (b2.ack0 !== 1'b0 || b2.busy !== 1'b0 || b2.rom_A !== 14'h0) begin
            $display("FAIL basic_release: ack0=%b busy=%b A=%h, want 0/0/0000", b2.ack0, b2.busy, b2.rom_A);
            errors++;
        end
    endtask

    task automatic test_wait0();
        int   sel_n, ack_k;
        bit   a_ok;
        exp_t e;
        sel_n = 0; ack_k = -1; a_ok = 1'b1;
        b0.addr1 = 14'h3FFF;
        b0.req1  = 1'b1;
        e.port = 1'b1; e.data = rom_f(14'h3FFF);
        sb.push_back(e);
        for (int i = 0; i < 20 && ack_k < 0; i++) begin
            @(negedge clk);
            if (sel0_low) begin
                sel_n++;
                if (b0.rom_A !== 14'h3FFF) a_ok = 1'b0;
            end
            if (b0.ack1) ack_k = i;
        end
        checks++;
        if (ack_k !== 2) begin $display("FAIL w0_latency: ack1 after edge t+%0d, want t+2", ack_k); errors++; end
        checks++;
        if (sel_n !== 1 || !a_ok) begin
            $display("FAIL w0_access: %0d select cycles addr_ok=%0d, want 1 cycle at 3FFF", sel_n, a_ok);
            errors++;
        end
        e = sb.pop_front();
        checks++;
        if (b0.rdata1 !== e.data || b0.ack0 !== 1'b0) begin
            $display("FAIL w0_rdata1: %h ack0=%b, want %h ack0=0", b0.rdata1, b0.ack0, e.data);
            errors++;
        end
        b0.req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (b0.ack1 !== 1'b0) begin $display("FAIL w0_release: ack1=%b, want 0", b0.ack1); errors++; end
    endtask

    task automatic test_arbitration();
        int         order[4];
        int         port, k;
        exp_t       e;
        logic [7:0] got;
`ifdef ROM_ARB_ROUND_ROBIN_EN
        order = '{0, 1, 0, 1};
`else
        order = '{0, 0, 0, 1};
`endif
        b2.addr0 = 14'h0010;
        b2.addr1 = 14'h0020;
        b2.req0  = 1'b1;
        b2.req1  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            e.port = order[g][0];
            e.data = rom_f(order[g] == 1 ? 14'h0020 : 14'h0010);
            sb.push_back(e);
        end
        for (int g = 0; g < 4; g++) begin
            wait_ack2(40, port, k);
            e   = sb.pop_front();
            got = (port == 1) ? b2.rdata1 : b2.rdata0;
            checks++;
            if (port !== int'(e.port) || got !== e.data) begin
                $display("FAIL arb_grant%0d: port %0d data %h, want port %0d data %h", g, port, got, e.port, e.data);
                errors++;
            end
            if (port < 0) begin
                sb.delete();
                break;
            end
            if (port == 0) b2.req0 = 1'b0; else b2.req1 = 1'b0;
            if (g < 2) begin
                @(negedge clk);
                if (port == 0) b2.req0 = 1'b1; else b2.req1 = 1'b1;
            end
        end
        b2.req0 = 1'b0;
        b2.req1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pending();
        int         port, k;
        exp_t       e;
        logic [7:0] old1;
        old1     = rom_f(14'h0020);
        b2.addr0 = 14'h0055;
        b2.req0  = 1'b1;
        e.port = 1'b0; e.data = rom_f(14'h0055); sb.push_back(e);
        e.port = 1'b1; e.data = rom_f(14'h0066); sb.push_back(e);
        @(negedge clk);
        b2.addr1 = 14'h0066;
        b2.req1  = 1'b1;
        wait_ack2(20, port, k);
        e = sb.pop_front();
        checks++;
        if (port !== 0 || k !== 3 || b2.rdata0 !== e.data) begin
            $display("FAIL pend_first: port %0d k %0d data %h, want port 0 k 3 data %h", port, k, b2.rdata0, e.data);
            errors++;
        end
        checks++;
        if (b2.rdata1 !== old1) begin $display("FAIL pend_loser_hold: rdata1 %h, want %h", b2.rdata1, old1); errors++; end
        b2.req0 = 1'b0;
        wait_ack2(20, port, k);
        e = sb.pop_front();
        checks++;
        if (port !== 1 || k !== 5 || b2.rdata1 !== e.data) begin
            $display("FAIL pend_second: port %0d k %0d data %h, want port 1 k 5 data %h", port, k, b2.rdata1, e.data);
            errors++;
        end
        b2.req1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_drop_in_access();
        int   n, first;
        exp_t e;
        n = 0; first = -1;
        b2.addr0 = 14'h0077;
        b2.req0  = 1'b1;
        e.port = 1'b0; e.data = rom_f(14'h0077);
        sb.push_back(e);
        @(negedge clk);
        b2.req0 = 1'b0;
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            if (b2.ack0) begin
                n++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (n !== 1 || first !== 4) begin
            $display("FAIL drop_pulse: ack0 high %0d cycles from t+%0d, want 1 cycle at t+4", n, first);
            errors++;
        end
        e = sb.pop_front();
        checks++;
        if (b2.rdata0 !== e.data || b2.busy !== 1'b0) begin
            $display("FAIL drop_data: rdata0 %h busy %b, want %h busy 0", b2.rdata0, b2.busy, e.data);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        int   port, k;
        exp_t e;
        b2.addr0 = 14'h0123;
        b2.req0  = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        checks++;
        if (sel2_any !== 1'b0 || b2.ack0 !== 1'b0 || b2.rdata0 !== 8'h00 || b2.busy !== 1'b0) begin
            $display("FAIL rstmid_abort: sel_any=%b ack0=%b rdata0=%h busy=%b, want 0/0/00/0",
                     sel2_any, b2.ack0, b2.rdata0, b2.busy);
            errors++;
        end
        rst_b   = 1'b1;
        b2.req0 = 1'b0;
        @(negedge clk);
        b2.addr0 = 14'h0101;
        b2.addr1 = 14'h0202;
        b2.req0  = 1'b1;
        b2.req1  = 1'b1;
        e.port = 1'b0; e.data = rom_f(14'h0101); sb.push_back(e);
        e.port = 1'b1; e.data = rom_f(14'h0202); sb.push_back(e);
        wait_ack2(20, port, k);
        e = sb.pop_front();
        checks++;
        if (port !== 0 || b2.rdata0 !== e.data) begin
            $display("FAIL rstmid_first_grant: port %0d data %h, want port 0 data %h", port, b2.rdata0, e.data);
            errors++;
        end
        b2.req0 = 1'b0;
        wait_ack2(20, port, k);
        e = sb.pop_front();
        checks++;
        if (port !== 1 || b2.rdata1 !== e.data) begin
            $display("FAIL rstmid_second_grant: port %0d data %h, want port 1 data %h", port, b2.rdata1, e.data);
            errors++;
        end
        b2.req1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_b  = 1'b0;
        b2.req0 = 1'b0; b2.req1 = 1'b0; b2.addr0 = '0; b2.addr1 = '0;
        b0.req0 = 1'b0; b0.req1 = 1'b0; b0.addr0 = '0; b0.addr1 = '0;
        // Invariants that must hold on every cycle: a single ack at a time, and the selects move together and only while busy.
        fork
            forever begin
                @(negedge clk);
                if (rst_b) begin
                    checks++;
                    if ((b2.ack0 && b2.ack1) || (b0.ack0 && b0.ack1) ||
                        (sel2_any && !(sel2_low && b2.busy)) || (sel0_any && !(sel0_low && b0.busy))) begin
                        $display("FAIL monitor: acks w2=%b%b w0=%b%b sel w2 any/all=%b%b busy=%b, want one ack max, selects only in access",
                                 b2.ack1, b2.ack0, b0.ack1, b0.ack0, sel2_any, sel2_low, b2.busy);
                        errors++;
                    end
                end
            end
        join_none
        test_reset();
        test_basic();
        test_wait0();
        test_arbitration();
        test_pending();
        test_drop_in_access();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
